// File: rtl/i2c_master_arbiter.sv
// Round-robin APB master that lends one i2c_master_top register block to N_REQ requesters,
// sequencing each granted transaction from prescaler setup through stop and clean-up.
module i2c_master_arbiter #(
    parameter int          N_REQ       = 4,
    parameter int          TIMEOUT_CYC = 65535,
    parameter logic [31:0] ADDR_PRESC  = 32'h00,
    parameter logic [31:0] ADDR_CMD    = 32'h01,
    parameter logic [31:0] ADDR_TX     = 32'h02,
    parameter logic [31:0] ADDR_RX     = 32'h03,
    parameter logic [31:0] ADDR_ADDRRW = 32'h04
) (
    input  logic               pclk_i,
    input  logic               preset_i,
    input  logic [7:0]         prescaler_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] addr_rw_i,
    input  logic [4*N_REQ-1:0] len_i,
    input  logic [8*N_REQ-1:0] wdata_i,
    output logic [N_REQ-1:0]   wdata_ack_o,
    output logic [7:0]         rdata_o,
    output logic [N_REQ-1:0]   rdata_valid_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [N_REQ-1:0]   err_o,
    input  logic               i2c_stop_i,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [31:0]        paddr_o,
    output logic [31:0]        pwdata_o,
    input  logic [31:0]        prdata_i,
    input  logic               pready_i
);
    // state   | meaning
    // IDLE    | arbitrate among req_i
    // CFG_P   | write prescaler
    // CFG_A   | write address_rw, load byte counter
    // PUSH    | write TX bytes
    // START   | enable core
    // WAIT    | wait for stop or timeout
    // POP     | read RX bytes
    // CLR     | disable core
    // DONE    | done pulse
    // ABORT   | reset core after timeout
    // ERR     | err pulse
    // Z0/Z1   | zero-length request, delay before err
    typedef enum logic [3:0] {
        S_IDLE, S_CFG_P, S_CFG_A, S_PUSH, S_START, S_WAIT, S_POP,
        S_CLR, S_DONE, S_ABORT, S_ERR, S_Z0, S_Z1
    } state_t;

    localparam int IW = $clog2(N_REQ);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic             rw_q, rw_d;
    logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, pick_idx, ptr_nxt;
    logic [N_REQ-1:0] grant_q, grant_d, rvalid_q, rvalid_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             found, xfer;
    logic [7:0]       cur_ar, cur_wdata;
    logic [3:0]       pick_len;
    int               j;
    logic             unused_prdata;

    assign unused_prdata = ^prdata_i[31:8];
    assign cur_ar        = addr_rw_i[8*int'(idx_q) +: 8];
    assign cur_wdata     = wdata_i[8*int'(idx_q) +: 8];
    assign pick_len      = len_i[4*int'(pick_idx) +: 4];
    assign ptr_nxt       = (idx_q == IW'(N_REQ-1)) ? '0 : idx_q + 1'b1;
    assign penable_o     = acc_q;
    assign xfer          = acc_q & pready_i;
    assign grant_o       = grant_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        rw_d        = rw_q;
        rdata_d     = rdata_q;
        rvalid_d    = '0;
        psel_o      = 1'b0;
        pwrite_o    = 1'b0;
        paddr_o     = '0;
        pwdata_o    = '0;
        wdata_ack_o = '0;
        done_o      = '0;
        err_o       = '0;
        case (state_q)
            S_IDLE: if (found) begin
                idx_d           = pick_idx;
                grant_d         = '0;
                grant_d[pick_idx] = 1'b1;
                state_d         = (pick_len == 4'd0) ? S_Z0 : S_CFG_P;
            end
            S_CFG_P: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_PRESC;
                pwdata_o = {24'h0, prescaler_i};
                if (xfer) state_d = S_CFG_A;
            end
            S_CFG_A: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_ADDRRW;
                pwdata_o = {24'h0, cur_ar};
                if (xfer) begin
                    cnt_d   = len_i[4*int'(idx_q) +: 4];
                    rw_d    = cur_ar[0];
                    state_d = cur_ar[0] ? S_START : S_PUSH;
                end
            end
            S_PUSH: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_TX;
                pwdata_o = {24'h0, cur_wdata};
                if (xfer) begin
                    wdata_ack_o[idx_q] = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_START;
                end
            end
            S_START: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_CMD;
                pwdata_o = 32'h60;
                if (xfer) begin
                    tmo_d   = TW'(TIMEOUT_CYC - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_stop_i)          state_d = rw_q ? S_POP : S_CLR;
                else if (tmo_q == '0)    state_d = S_ABORT;
                else                     tmo_d   = tmo_q - 1'b1;
            end
            S_POP: begin
                psel_o  = 1'b1;
                paddr_o = ADDR_RX;
                if (xfer) begin
                    rdata_d         = prdata_i[7:0];
                    rvalid_d[idx_q] = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_CLR;
                end
            end
            S_CLR: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_CMD;
                pwdata_o = 32'h20;
                if (xfer) state_d = S_DONE;
            end
            S_DONE: begin
                done_o[idx_q] = 1'b1;
                ptr_d   = ptr_nxt;
                grant_d = '0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                {psel_o, pwrite_o} = 2'b11;
                paddr_o  = ADDR_CMD;
                pwdata_o = 32'h00;
                if (xfer) state_d = S_ERR;
            end
            S_ERR: begin
                err_o[idx_q] = 1'b1;
                ptr_d   = ptr_nxt;
                grant_d = '0;
                state_d = S_IDLE;
            end
            S_Z0:    state_d = S_Z1;
            S_Z1:    state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        // ACCESS follows SETUP and holds until pready; the next SETUP waits a cycle
        acc_d = psel_o & ~xfer;
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q  <= S_IDLE;
            acc_q    <= 1'b0;
            rw_q     <= 1'b0;
            idx_q    <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rw_q     <= rw_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule
